// File: rtl/reg_bank_pkg.sv
// Shared types for the register-bank command sequencer.
// Ops, FSM states and default bank geometry.
package reg_bank_pkg;

   localparam int DEF_W = 7;
   localparam int DEF_N = 2;

   typedef enum logic [1:0] {
      OP_WRITE,
      OP_READ,
      OP_FILL,
      OP_CLEAR
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_RD,
      S_FILL,
      S_CHK,
      S_RESP
   } state_e;

endpackage

// File: rtl/reg_bank_seq.sv
// Command sequencer for the register bank: WRITE/READ/FILL/CLEAR in,
// one response beat out; drives bank we/addresses/data, samples rs1/rs2.
// Ports: clk, reset (sync, active-high); cmd_* valid/ready command port;
// rsp_* valid/ready response port; bank_* bank access signals.
// Build option REG_BANK_SEQ_VERIFY_EN: readback-check after every write.
module reg_bank_seq
   import reg_bank_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = DEF_N
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [N-1:0]      cmd_addr_a,
   input  logic [N-1:0]      cmd_addr_b,
   input  logic [W-1:0]      cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data_a,
   output logic [W-1:0]      rsp_data_b,
   output logic              rsp_err,
   output logic              bank_we,
   output logic [2**N-1:0]   bank_addr_rd,
   output logic [2**N-1:0]   bank_addr_rs1,
   output logic [2**N-1:0]   bank_addr_rs2,
   output logic [W-1:0]      bank_data_in,
   input  logic [W-1:0]      bank_rs1,
   input  logic [W-1:0]      bank_rs2
);

   localparam int DEPTH = 2**N;
   localparam int AW    = 2**N;

`ifdef REG_BANK_SEQ_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   state_e         state_q, state_d;
   op_e            op_q;
   op_e            cmd_op_e;
   logic [N-1:0]   a_q, b_q, cnt_q;
   logic [W-1:0]   d_q;
   logic [W-1:0]   rsp_a_q, rsp_b_q;
   logic           rsp_err_q;
   logic [N-1:0]   chk_addr_q;
   logic [W-1:0]   chk_val_q;

   logic           we;
   logic [N-1:0]   wr_addr;
   logic [W-1:0]   wr_val;
   logic           last;

   assign cmd_op_e = op_e'(cmd_op);
   assign last     = (cnt_q == N'(DEPTH - 1));

   // Write-side bus: only WR and FILL cycles put anything on it.
   always_comb begin
      we      = 1'b0;
      wr_addr = '0;
      wr_val  = '0;
      unique case (state_q)
         S_WR: begin
            we      = (a_q != '0);
            wr_addr = a_q;
            wr_val  = d_q;
         end
         S_FILL: begin
            we      = 1'b1;
            wr_addr = cnt_q;
            // FILL value wraps mod 2**W; CLEAR writes zero.
            wr_val  = (op_q == OP_FILL) ?
                      d_q + W'(cnt_q) - W'(1) : '0;
         end
         default: ;
      endcase
   end

   always_comb begin
      bank_addr_rs1 = '0;
      bank_addr_rs2 = '0;
      unique case (state_q)
         S_RD: begin
            bank_addr_rs1 = AW'(a_q);
            bank_addr_rs2 = AW'(b_q);
         end
         S_CHK:   bank_addr_rs1 = AW'(chk_addr_q);
         default: ;
      endcase
   end

   assign bank_we      = we;
   assign bank_addr_rd = AW'(wr_addr);
   assign bank_data_in = wr_val;

   assign cmd_ready  = (state_q == S_IDLE);
   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_data_a = rsp_a_q;
   assign rsp_data_b = rsp_b_q;
   assign rsp_err    = rsp_err_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               unique case (1'b1)
                  (cmd_op_e == OP_WRITE): state_d = S_WR;
                  (cmd_op_e == OP_READ):  state_d = S_RD;
                  default:                state_d = S_FILL;
               endcase
            end
         end
         S_WR:   state_d = VERIFY ? S_CHK : S_RESP;
         S_RD:   state_d = S_RESP;
         S_FILL: begin
            if (VERIFY)    state_d = S_CHK;
            else if (last) state_d = S_RESP;
            else           state_d = S_FILL;
         end
         S_CHK: begin
            if (op_q == OP_WRITE || last) state_d = S_RESP;
            else                          state_d = S_FILL;
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         op_q       <= OP_WRITE;
         a_q        <= '0;
         b_q        <= '0;
         d_q        <= '0;
         cnt_q      <= '0;
         rsp_a_q    <= '0;
         rsp_b_q    <= '0;
         rsp_err_q  <= 1'b0;
         chk_addr_q <= '0;
         chk_val_q  <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op_e;
                  a_q       <= cmd_addr_a;
                  b_q       <= cmd_addr_b;
                  d_q       <= cmd_data;
                  cnt_q     <= N'(1);
                  rsp_err_q <= 1'b0;
               end
            end
            S_WR: begin
               rsp_a_q    <= d_q;
               rsp_b_q    <= '0;
               rsp_err_q  <= (a_q == '0);
               chk_addr_q <= a_q;
               chk_val_q  <= d_q;
            end
            S_RD: begin
               rsp_a_q   <= bank_rs1;
               rsp_b_q   <= bank_rs2;
               rsp_err_q <= 1'b0;
            end
            S_FILL: begin
               rsp_a_q    <= wr_val;
               rsp_b_q    <= W'(DEPTH - 1);
               chk_addr_q <= cnt_q;
               chk_val_q  <= wr_val;
               // With readback the counter advances after the check.
               if (!VERIFY) cnt_q <= cnt_q + N'(1);
            end
            S_CHK: begin
               if (bank_rs1 != chk_val_q) rsp_err_q <= 1'b1;
               cnt_q <= cnt_q + N'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_seq.sv
// Bench for reg_bank_seq: behavioural bank plus array-based reference
// of bank contents, write traces, response values and latencies.
module tb_reg_bank_seq;

   localparam int W     = 7;
   localparam int N     = 2;
   localparam int DEPTH = 4;
   localparam int AW    = 4;

`ifdef REG_BANK_SEQ_VERIFY_EN
   localparam int WR_LAT = 3;
   localparam int FL_LAT = 2 * (DEPTH - 1) + 1;
`else
   localparam int WR_LAT = 2;
   localparam int FL_LAT = DEPTH;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [N-1:0]  cmd_addr_a;
   logic [N-1:0]  cmd_addr_b;
   logic [W-1:0]  cmd_data;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_data_a;
   logic [W-1:0]  rsp_data_b;
   logic          rsp_err;
   logic          bank_we;
   logic [AW-1:0] bank_addr_rd;
   logic [AW-1:0] bank_addr_rs1;
   logic [AW-1:0] bank_addr_rs2;
   logic [W-1:0]  bank_data_in;
   logic [W-1:0]  bank_rs1;
   logic [W-1:0]  bank_rs2;

   reg_bank_seq #(.W(W), .N(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_op        (cmd_op),
      .cmd_addr_a    (cmd_addr_a),
      .cmd_addr_b    (cmd_addr_b),
      .cmd_data      (cmd_data),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_data_a    (rsp_data_a),
      .rsp_data_b    (rsp_data_b),
      .rsp_err       (rsp_err),
      .bank_we       (bank_we),
      .bank_addr_rd  (bank_addr_rd),
      .bank_addr_rs1 (bank_addr_rs1),
      .bank_addr_rs2 (bank_addr_rs2),
      .bank_data_in  (bank_data_in),
      .bank_rs1      (bank_rs1),
      .bank_rs2      (bank_rs2)
   );

   always #5 clk = ~clk;

   // Bank: entry 0 stays zero, shares the sequencer reset.
   logic [W-1:0] bmem [DEPTH];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) bmem[i] <= '0;
      end else if (bank_we && bank_addr_rd < AW'(DEPTH)
                   && bank_addr_rd != '0) begin
         bmem[bank_addr_rd[N-1:0]] <= bank_data_in;
      end
   end

   assign bank_rs1 = bmem[bank_addr_rs1[N-1:0]];
   assign bank_rs2 = bmem[bank_addr_rs2[N-1:0]];

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   logic [W-1:0] ref_mem [DEPTH];

   logic [1:0]   nx_op;
   logic [N-1:0] nx_a, nx_b;
   logic [W-1:0] nx_d;

   task automatic run_cmd(input logic [1:0]   op,
                          input logic [N-1:0] a,
                          input logic [N-1:0] b,
                          input logic [W-1:0] d,
                          input int           hold,
                          input bit           pend);
      logic [W-1:0] ea, eb, v;
      logic         ee;
      int           lat;
      int           qa[$];
      logic [W-1:0] qd[$];
      bit           got;
      ea  = '0;
      eb  = '0;
      ee  = 1'b0;
      lat = 2;
      case (op)
         2'd0: begin
            ea  = d;
            ee  = (a == '0);
            lat = WR_LAT;
            if (a != '0) begin
               qa.push_back(int'(a));
               qd.push_back(d);
               ref_mem[a] = d;
            end
         end
         2'd1: begin
            ea = ref_mem[a];
            eb = ref_mem[b];
         end
         default: begin
            for (int i = 1; i < DEPTH; i++) begin
               v = (op == 2'd2) ? W'(int'(d) + i - 1) : '0;
               qa.push_back(i);
               qd.push_back(v);
               ref_mem[i] = v;
               ea = v;
            end
            eb  = W'(DEPTH - 1);
            lat = FL_LAT;
         end
      endcase

      chk("cmd_ready_idle", 32'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_addr_a = a;
      cmd_addr_b = b;
      cmd_data   = d;
      got = 1'b0;
      for (int k = 1; k <= 40 && !got; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) cmd_valid = 1'b0;
         if (bank_we) begin
            if (qa.size() == 0) begin
               chk("we_extra", 1, 0);
            end else begin
               chk("we_addr", 32'(bank_addr_rd), qa.pop_front());
               chk("we_data", 32'(bank_data_in), 32'(qd.pop_front()));
            end
         end
         if (rsp_valid) begin
            got = 1'b1;
            chk("latency", k, lat);
         end else begin
            chk("busy_ready", 32'(cmd_ready), 0);
         end
      end
      if (!got) begin
         chk("rsp_timeout", 0, 1);
         return;
      end
      chk("we_left", qa.size(), 0);
      chk("bus_idle", 32'({bank_we, bank_addr_rd, bank_addr_rs1,
                           bank_addr_rs2, bank_data_in}), 0);
      if (pend) begin
         cmd_valid  = 1'b1;
         cmd_op     = nx_op;
         cmd_addr_a = nx_a;
         cmd_addr_b = nx_b;
         cmd_data   = nx_d;
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_a", 32'(rsp_data_a), 32'(ea));
         chk("hold_b", 32'(rsp_data_b), 32'(eb));
         chk("hold_err", 32'(rsp_err), 32'(ee));
         if (pend) chk("hold_ready", 32'(cmd_ready), 0);
      end
      chk("rsp_a", 32'(rsp_data_a), 32'(ea));
      chk("rsp_b", 32'(rsp_data_b), 32'(eb));
      chk("rsp_err", 32'(rsp_err), 32'(ee));
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 0);
      chk("ready_back", 32'(cmd_ready), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ready"}, 32'(cmd_ready), 1);
      chk({tag, "_rvalid"}, 32'(rsp_valid), 0);
      chk({tag, "_rsp"}, 32'({rsp_data_a, rsp_data_b, rsp_err}), 0);
      chk({tag, "_bus"}, 32'({bank_we, bank_addr_rd, bank_addr_rs1,
                              bank_addr_rs2, bank_data_in}), 0);
   endtask

   logic [1:0]   r_op;
   logic [N-1:0] r_a, r_b;
   logic [W-1:0] r_d;
   bit           p, np;

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = '0;
      cmd_addr_a = '0;
      cmd_addr_b = '0;
      cmd_data   = '0;
      rsp_ready  = 1'b0;
      nx_op = '0; nx_a = '0; nx_b = '0; nx_d = '0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outs("reset");
      reset = 1'b0;
      @(posedge clk);
      #1;

      // 1,2: write then read back
      run_cmd(2'd0, 2'd2, 2'd0, 7'h55, 0, 0);
      run_cmd(2'd1, 2'd2, 2'd0, 7'h00, 1, 0);
      // 3: write to entry 0
      run_cmd(2'd0, 2'd0, 2'd0, 7'h7F, 0, 0);
      run_cmd(2'd1, 2'd0, 2'd0, 7'h00, 0, 0);
      // 4: fill with wrap, read, clear, read
      run_cmd(2'd2, 2'd0, 2'd0, 7'h7E, 0, 0);
      run_cmd(2'd1, 2'd1, 2'd2, 7'h00, 0, 0);
      run_cmd(2'd1, 2'd3, 2'd0, 7'h00, 0, 0);
      run_cmd(2'd3, 2'd0, 2'd0, 7'h12, 0, 0);
      run_cmd(2'd1, 2'd1, 2'd3, 7'h00, 0, 0);
      // 5: stalled response with a queued command
      nx_op = 2'd1; nx_a = 2'd1; nx_b = 2'd2; nx_d = 7'h00;
      run_cmd(2'd0, 2'd1, 2'd0, 7'h11, 5, 1);
      run_cmd(nx_op, nx_a, nx_b, nx_d, 0, 0);

      // random traffic
      p = 1'b0;
      for (int it = 0; it < 40; it++) begin
         if (p) begin
            r_op = nx_op; r_a = nx_a; r_b = nx_b; r_d = nx_d;
         end else begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = N'($urandom_range(0, DEPTH - 1));
            r_b  = N'($urandom_range(0, DEPTH - 1));
            r_d  = W'($urandom);
         end
         np = 1'($urandom_range(0, 1));
         if (np) begin
            nx_op = 2'($urandom_range(0, 3));
            nx_a  = N'($urandom_range(0, DEPTH - 1));
            nx_b  = N'($urandom_range(0, DEPTH - 1));
            nx_d  = W'($urandom);
         end
         run_cmd(r_op, r_a, r_b, r_d, $urandom_range(0, 3), np);
         p = np;
      end

      // 6: reset during a FILL
      chk("t6_idle", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      cmd_data  = 7'h33;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("t6_fill_we", 32'(bank_we), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outs("t6_reset");
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("t6_no_rsp", 32'(rsp_valid), 0);
      end
      run_cmd(2'd1, 2'd1, 2'd2, 7'h00, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
